// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and widths for the execute stage and its alu.
//                alu_op_t     - alu opcode encoding
//                exec_slot_t  - one buffered result (result, rd, zero, carry)
//                exec_state_t - occupancy of the 2-entry elastic buffer
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int WIDTH = 8;
  localparam int RD_W  = 3;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001
  } alu_op_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [RD_W-1:0]  rd;
    logic             zero;
    logic             carry;
  } exec_slot_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } exec_state_t;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Purely combinational WIDTH-bit alu. Results wrap modulo
//                2^WIDTH; any opcode other than ADD/SUB yields zero.
//  Ports       : op_i     [3:0]       opcode (alu_op_t encoding)
//                a_i      [WIDTH-1:0] operand 0
//                b_i      [WIDTH-1:0] operand 1
//                result_o [WIDTH-1:0] result
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
  import cpu_pkg::*;
(
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      default: result_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_stage
//  Description : Execute stage around the alu. Ops from decode are computed
//                at accept time and stored in a 2-entry elastic buffer
//                (head + skid) that feeds writeback, breaking the
//                decode->alu->regfile combinational path.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                flush               drop all buffered and incoming ops
//                in_valid/in_ready   decode handshake
//                in_op/in_a/in_b     opcode and operands
//                in_rd               destination register
//                out_valid/out_ready writeback handshake
//                out_result/out_rd   buffered result and destination
//                out_zero/out_carry  result==0, carry (ADD) / borrow (SUB)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [RD_W-1:0]  in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_zero,
  output logic             out_carry
);

  exec_state_t      state_q;
  exec_slot_t       head_q;
  exec_slot_t       skid_q;

  logic [WIDTH-1:0] alu_result;
  logic             add_carry;
  logic             sub_borrow;
  exec_slot_t       new_slot;
  logic             accept;
  logic             pop;

  alu u_alu (
    .op_i     (in_op),
    .a_i      (in_a),
    .b_i      (in_b),
    .result_o (alu_result)
  );

  // Carry is bit WIDTH of the (WIDTH+1)-bit sum, i.e. the sum exceeds all-ones.
  assign add_carry  = ({1'b0, in_a} + {1'b0, in_b}) > {1'b0, {WIDTH{1'b1}}};
  assign sub_borrow = in_a < in_b;

  always_comb begin
    new_slot        = '0;
    new_slot.result = alu_result;
    new_slot.rd     = in_rd;
    new_slot.zero   = (alu_result == '0);
    case (in_op)
      ALU_ADD: new_slot.carry = add_carry;
      ALU_SUB: new_slot.carry = sub_borrow;
      default: new_slot.carry = 1'b0;
    endcase
  end

  // Ready depends only on occupancy, never on out_ready, so no
  // combinational path runs from writeback back to decode.
  assign in_ready  = !rst && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_result = head_q.result;
  assign out_rd     = head_q.rd;
  assign out_zero   = head_q.zero;
  assign out_carry  = head_q.carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      // Data regs keep their contents; out_valid=0 makes them don't-care.
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_q  <= new_slot;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            skid_q  <= new_slot;
            state_q <= FULL;
          end else if (accept && pop) begin
            head_q  <= new_slot;
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_stage
//  Description : Self-checking bench for alu_exec_stage. The driver pushes
//                the expected slot on every accepted op; the monitor pops and
//                compares on every writeback handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_op = 4'h0;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic [2:0] in_rd = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
  logic [2:0] out_rd;
  logic       out_zero;
  logic       out_carry;

  int n_checks = 0;
  int n_fail   = 0;
  logic [12:0] exp_q[$];
  logic        stop_throttle = 1'b0;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_zero   (out_zero),
    .out_carry  (out_carry)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {result, rd, zero, carry} from plain 9-bit arithmetic.
  function automatic logic [12:0] model(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [2:0] rd);
    logic [8:0] s;
    s = 9'd0;
    if (op == 4'h0)      s = {1'b0, a} + {1'b0, b};
    else if (op == 4'h1) s = {1'b0, a} - {1'b0, b};
    return {s[7:0], rd, (s[7:0] == 8'h00), s[8]};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_op(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] rd);
    bit acc;
    acc = 0;
    in_op = op; in_a = a; in_b = b; in_rd = rd; in_valid = 1'b1;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) acc = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (acc) exp_q.push_back(model(op, a, b, rd));
    else check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: compare on every handshake, and check outputs hold while stalled.
  logic        prev_stall = 1'b0;
  logic [12:0] held = '0;
  always @(negedge clk) begin
    logic [12:0] cur;
    cur = {out_result, out_rd, out_zero, out_carry};
    if (out_valid === 1'b1 && prev_stall) check("hold_stable", {19'd0, cur}, {19'd0, held});
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_output", {19'd0, cur}, 32'hFFFF_FFFF);
      else check("result", {19'd0, cur}, {19'd0, exp_q.pop_front()});
    end
    prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
    held = cur;
  end

  initial begin
    // 1. reset
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", {24'd0, out_result}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // 2. ADD with carry, latency of one cycle
    out_ready = 1'b1;
    send_op(4'h0, 8'hF0, 8'h20, 3'd3);
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    repeat (2) @(posedge clk); #1;

    // 3. SUB to zero, SUB with borrow
    send_op(4'h1, 8'h05, 8'h05, 3'd1);
    send_op(4'h1, 8'h03, 8'h04, 3'd2);
    repeat (2) @(posedge clk); #1;

    // 4. back-pressure: third op held until writeback drains
    out_ready = 1'b0;
    send_op(4'h0, 8'h11, 8'h22, 3'd4);
    send_op(4'h1, 8'h50, 8'h10, 3'd5);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    fork
      send_op(4'h0, 8'h80, 8'h80, 3'd6);
      begin
        repeat (3) @(posedge clk); #1;
        check("held_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;

    // 5. flush while FULL with a concurrent incoming op
    out_ready = 1'b0;
    send_op(4'h0, 8'h01, 8'h02, 3'd7);
    send_op(4'h0, 8'h03, 8'h04, 3'd0);
    in_op = 4'h0; in_a = 8'h55; in_b = 8'h01; in_rd = 3'd1;
    in_valid = 1'b1;
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk); #1;

    // 6. unknown opcode
    send_op(4'hF, 8'h12, 8'h34, 3'd2);
    repeat (2) @(posedge clk); #1;

    // random throttled traffic
    fork
      begin
        while (!stop_throttle) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int n = 0; n < 1000; n++) begin
          logic [3:0] op;
          int sel;
          sel = $urandom_range(0, 9);
          op = (sel < 4) ? 4'h0 : (sel < 8) ? 4'h1 : 4'($urandom_range(2, 15));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send_op(op, 8'($urandom), 8'($urandom), 3'($urandom));
        end
        stop_throttle = 1'b1;
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
